// File: rtl/mealy_seq_detector_if.sv
// Serial-stream and configuration bundle for the programmable Mealy detector.
interface mealy_seq_detector_if #(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8
);
    localparam int LW = $clog2(MAX_LEN + 1);

    logic               in;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] cfg_pattern;
    logic [LW-1:0]      cfg_len;
    logic               cfg_overlap;
    logic               clr_count;
    logic               out;
    logic [CNT_W-1:0]   match_count;
    logic               count_sat;
    logic               cfg_err;

    // Stream/config source side
    modport master (
        output in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
        input  out, match_count, count_sat, cfg_err
    );

    // Detector side
    modport slave (
        input  in, in_valid, cfg_load, cfg_pattern, cfg_len, cfg_overlap, clr_count,
        output out, match_count, count_sat, cfg_err
    );
endinterface

// File: rtl/mealy_seq_detector.sv
// Runtime-programmable Mealy serial-pattern detector with a saturating match counter.
// out is combinational: it fires in the same cycle the final pattern bit is presented.
module mealy_seq_detector #(
    parameter int               MAX_LEN     = 8,
    parameter int               CNT_W       = 8,
    parameter logic [MAX_LEN-1:0] RST_PATTERN = 'b110,
    parameter int               RST_LEN     = 3,
    parameter bit               RST_OVERLAP = 1'b1
) (
    input logic                  clk,
    input logic                  rst,
    mealy_seq_detector_if.slave  bus
);
    localparam int            LW    = $clog2(MAX_LEN + 1);
    localparam logic [LW-1:0] MAX_L = LW'(MAX_LEN);

    logic [MAX_LEN-1:0] hist;
    logic [MAX_LEN-1:0] pattern;
    logic [LW-1:0]      len;
    logic [LW-1:0]      fill;
    logic               overlap;
    logic [CNT_W-1:0]   count;
    logic               err;

    logic [MAX_LEN-1:0] cand;
    logic [MAX_LEN-1:0] mask;
    logic               pat_hit;
    logic               fill_ok;
    logic               match;
    logic               cfg_ok;
    logic               sat;

    // Candidate window (history plus the bit on the wire) compared against the low len pattern bits
    always_comb begin
        mask = '0;
        for (int i = 0; i < MAX_LEN; i++)
            mask[i] = (i < int'(len));
        cand    = {hist[MAX_LEN-2:0], bus.in};
        pat_hit = &(~(cand ^ pattern) | ~mask);
        // enough history: fill >= len-1, done as fill+1 >= len to avoid underflow
        fill_ok = ((LW+1)'(fill) + (LW+1)'(1)) >= (LW+1)'(len);
        match   = bus.in_valid & ~bus.cfg_load & ~rst & fill_ok & pat_hit;
        cfg_ok  = (bus.cfg_len != '0) && (bus.cfg_len <= MAX_L);
        sat     = &count;
    end

    assign bus.out         = match;
    assign bus.match_count = count;
    assign bus.count_sat   = sat;
    assign bus.cfg_err     = err;

    // Shift history, track fill level and apply configuration loads
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hist    <= '0;
            fill    <= '0;
            pattern <= RST_PATTERN;
            len     <= LW'(RST_LEN);
            overlap <= RST_OVERLAP;
            err     <= 1'b0;
        end else begin
            err <= bus.cfg_load & ~cfg_ok;
            if (bus.cfg_load) begin
                // a rejected load leaves everything as it was; the input bit is dropped either way
                if (cfg_ok) begin
                    pattern <= bus.cfg_pattern;
                    len     <= bus.cfg_len;
                    overlap <= bus.cfg_overlap;
                    hist    <= '0;
                    fill    <= '0;
                end
            end else if (bus.in_valid) begin
                hist <= {hist[MAX_LEN-2:0], bus.in};
                if (match && !overlap)
                    fill <= '0;
                else if (fill != MAX_L)
                    fill <= fill + LW'(1);
            end
        end
    end

    // Saturating match counter; a clear coinciding with a match counts that match
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            count <= '0;
        else if (bus.clr_count && match)
            count <= CNT_W'(1);
        else if (bus.clr_count)
            count <= '0;
        else if (match && !sat)
            count <= count + CNT_W'(1);
    end
endmodule

// File: tb/tb_mealy_seq_detector.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a monitor pops and compares.
module tb_mealy_seq_detector;
    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mealy_seq_detector_if #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) bus ();

    mealy_seq_detector #(
        .MAX_LEN(MAX_LEN), .CNT_W(CNT_W), .RST_PATTERN(8'b110),
        .RST_LEN(3), .RST_OVERLAP(1'b1)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic       o;
        logic [1:0] c;
        logic       s;
        logic       e;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // model of registered outputs (value visible during the next stimulus cycle)
    logic [1:0] m_cnt = 2'd0;
    logic       m_err = 1'b0;

    task automatic chk(input string n, input int act, input int expv);
        checks++;
        if (act !== expv) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", n, act, expv, $time);
        end
    endtask

    // One stimulus cycle: drive after negedge, record what the monitor must see before the next posedge
    task automatic step(input logic i, input logic v, input logic exp_o,
                        input logic ld = 1'b0, input logic [7:0] pat = 8'h0,
                        input logic [3:0] ln = 4'd0, input logic ov = 1'b0,
                        input logic clr = 1'b0, input logic r = 1'b0);
        exp_t e;
        @(negedge clk);
        #1;
        rst             = r;
        bus.in          = i;
        bus.in_valid    = v;
        bus.cfg_load    = ld;
        bus.cfg_pattern = pat;
        bus.cfg_len     = ln;
        bus.cfg_overlap = ov;
        bus.clr_count   = clr;
        if (r) begin
            m_cnt = 2'd0;
            m_err = 1'b0;
        end
        e.o = exp_o;
        e.c = m_cnt;
        e.s = (m_cnt == 2'd3);
        e.e = m_err;
        q.push_back(e);
        if (!r) begin
            m_err = ld && (ln == 4'd0 || ln > 4'd8);
            if (clr && exp_o)       m_cnt = 2'd1;
            else if (clr)           m_cnt = 2'd0;
            else if (exp_o && m_cnt != 2'd3) m_cnt = m_cnt + 2'd1;
        end
    endtask

    task automatic idle(input logic clr = 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 4'd0, 1'b0, clr);
    endtask

    task automatic load(input logic [7:0] pat, input logic [3:0] ln, input logic ov);
        step(1'b1, 1'b1, 1'b0, 1'b1, pat, ln, ov);
    endtask

    task automatic stream(input logic [15:0] bits, input logic [15:0] exp, input int n);
        for (int k = n - 1; k >= 0; k--)
            step(bits[k], 1'b1, exp[k]);
    endtask

    // Monitor: compare every presented cycle against the oldest expectation
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #3;
            if (q.size() > 0) begin
                e = q.pop_front();
                chk("out",         int'(bus.out),         int'(e.o));
                chk("match_count", int'(bus.match_count), int'(e.c));
                chk("count_sat",   int'(bus.count_sat),   int'(e.s));
                chk("cfg_err",     int'(bus.cfg_err),     int'(e.e));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, checks=%0d", checks);
        $fatal(1, "timeout");
    end

    initial begin
        bus.in = 0; bus.in_valid = 0; bus.cfg_load = 0; bus.cfg_pattern = 0;
        bus.cfg_len = 0; bus.cfg_overlap = 0; bus.clr_count = 0;

        // reset state, then default 110 detection
        step(1'b1, 1'b1, 1'b0, 1'b0, 8'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        stream(16'b110, 16'b001, 3);
        idle();

        // overlapping default stream, count ends at 3 (saturated for CNT_W=2)
        idle(1'b1);
        stream(16'b11_0110_1110, 16'b00_1001_0001, 10);
        idle();

        // 1011 overlapping: matches on bits 4 and 7
        idle(1'b1);
        load(8'b1011, 4'd4, 1'b1);
        stream(16'b1011011, 16'b0001001, 7);
        // 1011 non-overlapping: match on bit 4 only
        load(8'b1011, 4'd4, 1'b0);
        stream(16'b1011011, 16'b0001000, 7);

        // default pattern with gaps; count already saturated and must hold
        load(8'b110, 4'd3, 1'b1);
        step(1'b1, 1'b1, 1'b0);
        idle(); idle(); idle();
        step(1'b1, 1'b1, 1'b0);
        idle();
        step(1'b0, 1'b1, 1'b1);
        idle();

        // five matches saturate at 3, then clear coinciding with a match gives 1
        idle(1'b1);
        for (int k = 0; k < 5; k++) stream(16'b110, 16'b001, 3);
        step(1'b1, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        step(1'b0, 1'b1, 1'b1, 1'b0, 8'h0, 4'd0, 1'b0, 1'b1);
        idle();

        // length-1 boundary, non-overlapping
        load(8'b1, 4'd1, 1'b0);
        stream(16'b101, 16'b101, 3);
        load(8'b110, 4'd3, 1'b1);
        stream(16'b110, 16'b001, 3);

        // illegal loads: len 0 and len 9 rejected, history and config kept
        load(8'hFF, 4'd0, 1'b0);
        idle();
        load(8'hFF, 4'd9, 1'b0);
        stream(16'b110, 16'b001, 3);

        // reset mid-pattern aborts the partial match
        stream(16'b11, 16'b00, 2);
        step(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 4'd0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b1, 1'b0);
        idle();

        repeat (3) @(negedge clk);
        chk("queue_drained", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
